// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and hazard controller: prioritised operand forwarding,
// load-use and multicycle RAW/structural stall detection, and a stall counter.
module fwd_hazard_ctrl #(
    parameter  int AW    = 5,
    parameter  int NFWD  = 2,
    parameter  int LATW  = 4,
    localparam int SEL_W = $clog2(NFWD + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [NFWD-1:0]      src_regwrite,
    input  logic [NFWD*AW-1:0]   src_rd,
    input  logic [NFWD-1:0]      src_ready,
    input  logic                 mc_start,
    input  logic [AW-1:0]        mc_rd,
    input  logic [LATW-1:0]      mc_lat,
    output logic [SEL_W-1:0]     fwd_a,
    output logic [SEL_W-1:0]     fwd_b,
    output logic                 stall,
    output logic                 mc_busy,
    output logic                 mc_wb,
    output logic [AW-1:0]        mc_wb_rd,
    output logic [15:0]          stall_cnt
);

    localparam logic [SEL_W-1:0] MC_SEL = SEL_W'(NFWD + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic             hit;
        logic             rdy;
        logic [SEL_W-1:0] sel;
    } pick_t;

    state_t            state, state_nxt;
    logic [LATW-1:0]   cnt;
    logic [AW-1:0]     rd;
    logic              mc_load;
    logic              raw_a, raw_b;
    pick_t             pick_a, pick_b;

    // Scan from oldest to youngest so the lowest matching index wins.
    function automatic pick_t pick_src(
        input logic [AW-1:0]      rs,
        input logic               used,
        input logic [NFWD-1:0]    regwrite,
        input logic [NFWD*AW-1:0] rd_vec,
        input logic [NFWD-1:0]    ready
    );
        pick_t p;
        p = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (used && regwrite[k] && (rd_vec[k*AW +: AW] != '0) &&
                (rd_vec[k*AW +: AW] == rs)) begin
                p.hit = 1'b1;
                p.rdy = ready[k];
                p.sel = SEL_W'(k + 1);
            end
        end
        return p;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [LATW-1:0] eff_lat(input logic [LATW-1:0] lat);
        return (lat == '0) ? LATW'(1) : lat;
    endfunction

    // Forward selects and stall: purely combinational on inputs and state
    always_comb begin
        pick_a = pick_src(rs1, rs1_used, src_regwrite, src_rd, src_ready);
        pick_b = pick_src(rs2, rs2_used, src_regwrite, src_rd, src_ready);

        fwd_a = pick_a.sel;
        if (!pick_a.hit && rs1_used && (rs1 != '0) && (state == DONE) && (rd == rs1))
            fwd_a = MC_SEL;
        fwd_b = pick_b.sel;
        if (!pick_b.hit && rs2_used && (rs2 != '0) && (state == DONE) && (rd == rs2))
            fwd_b = MC_SEL;

        raw_a = !pick_a.hit && rs1_used && (rs1 != '0) && (state == BUSY) && (rd == rs1);
        raw_b = !pick_b.hit && rs2_used && (rs2 != '0) && (state == BUSY) && (rd == rs2);

        stall = (pick_a.hit && !pick_a.rdy) || (pick_b.hit && !pick_b.rdy) ||
                raw_a || raw_b || (mc_start && (state == BUSY));
    end

    // Multicycle FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mc_start) state_nxt = BUSY;
            BUSY:    if (cnt == LATW'(1)) state_nxt = DONE;
            DONE:    state_nxt = mc_start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mc_busy  = (state == BUSY);
        mc_wb    = (state == DONE);
        mc_wb_rd = (state == DONE) ? rd : '0;
    end

    // A start seen while BUSY is the structural hazard and is dropped here.
    assign mc_load = mc_start && (state != BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            rd  <= '0;
        end else if (mc_load) begin
            cnt <= eff_lat(mc_lat);
            rd  <= mc_rd;
        end else if (state == BUSY) begin
            cnt <= cnt - LATW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     stall_cnt <= '0;
        else if (stall) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed self-checking bench for fwd_hazard_ctrl with hand-computed expectations.
module tb_fwd_hazard_ctrl;

    localparam int AW = 5, NFWD = 2, LATW = 4, SEL_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [AW-1:0]      rs1, rs2;
    logic               rs1_used, rs2_used;
    logic [NFWD-1:0]    src_regwrite, src_ready;
    logic [NFWD*AW-1:0] src_rd;
    logic               mc_start;
    logic [AW-1:0]      mc_rd;
    logic [LATW-1:0]    mc_lat;
    logic [SEL_W-1:0]   fwd_a, fwd_b;
    logic               stall, mc_busy, mc_wb;
    logic [AW-1:0]      mc_wb_rd;
    logic [15:0]        stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fwd_hazard_ctrl #(.AW(AW), .NFWD(NFWD), .LATW(LATW)) dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .src_regwrite(src_regwrite), .src_rd(src_rd), .src_ready(src_ready),
        .mc_start(mc_start), .mc_rd(mc_rd), .mc_lat(mc_lat),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .mc_busy(mc_busy), .mc_wb(mc_wb), .mc_wb_rd(mc_wb_rd), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        src_regwrite = '0; src_rd = '0; src_ready = '0;
        mc_start = 1'b0; mc_rd = '0; mc_lat = '0;
        #1;
        chk("rst_busy", mc_busy, 0);
        chk("rst_wb", mc_wb, 0);
        chk("rst_wb_rd", mc_wb_rd, 0);
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_stall", stall, 0);
        #12 rst_n = 1'b1;
        tick();

        // Priority forwarding
        src_regwrite = 2'b11; src_rd = {5'd5, 5'd5}; src_ready = 2'b11;
        rs1 = 5'd5; rs1_used = 1'b1;
        #1;
        chk("prio_both", fwd_a, 1);
        chk("prio_stall", stall, 0);
        src_regwrite = 2'b10; #1;
        chk("prio_src1", fwd_a, 2);
        src_regwrite = 2'b11; src_rd = '0; rs1 = '0; #1;
        chk("prio_x0", fwd_a, 0);
        src_rd = {5'd5, 5'd5}; rs1 = 5'd5; rs1_used = 1'b0; #1;
        chk("prio_unused", fwd_a, 0);

        // Load-use stall
        src_regwrite = 2'b01; src_rd = {5'd0, 5'd7}; src_ready = 2'b00;
        rs2 = 5'd7; rs2_used = 1'b1;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_fwd_b", fwd_b, 1);
        chk("lu_cnt0", stall_cnt, 0);
        tick();
        chk("lu_cnt1", stall_cnt, 1);
        src_ready = 2'b01; #1;
        chk("lu_ready_stall", stall, 0);
        chk("lu_ready_fwd_b", fwd_b, 1);
        // Older source not ready, but the younger winner is ready
        src_regwrite = 2'b11; src_rd = {5'd7, 5'd7}; src_ready = 2'b01; #1;
        chk("lu_old_notready", stall, 0);
        src_regwrite = '0; src_rd = '0; src_ready = '0; rs2_used = 1'b0; rs2 = '0;
        #1;

        // Multicycle RAW: start rd=9 lat=3
        rs1 = '0; rs1_used = 1'b0;
        mc_start = 1'b1; mc_rd = 5'd9; mc_lat = 4'd3; #1;
        chk("mc_idle_start_stall", stall, 0);
        tick();
        mc_start = 1'b0; rs1 = 5'd9; rs1_used = 1'b1; #1;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("mc_busy_c%0d", c), mc_busy, 1);
            chk($sformatf("mc_raw_c%0d", c), stall, 1);
            chk($sformatf("mc_fwd_c%0d", c), fwd_a, 0);
            tick();
        end
        chk("mc_c4_wb", mc_wb, 1);
        chk("mc_c4_wb_rd", mc_wb_rd, 9);
        chk("mc_c4_fwd_a", fwd_a, 3);
        chk("mc_c4_stall", stall, 0);
        chk("mc_c4_busy", mc_busy, 0);
        chk("mc_c4_cnt", stall_cnt, 4);
        tick();
        chk("mc_c5_wb", mc_wb, 0);
        chk("mc_c5_busy", mc_busy, 0);
        chk("mc_c5_fwd_a", fwd_a, 0);
        rs1_used = 1'b0; rs1 = '0;

        // Structural and chained starts
        mc_start = 1'b1; mc_rd = 5'd10; mc_lat = 4'd2;
        tick();
        mc_rd = 5'd11; mc_lat = 4'd5; #1;
        chk("st_c1_busy", mc_busy, 1);
        chk("st_c1_stall", stall, 1);
        tick();
        chk("st_c2_busy", mc_busy, 1);
        chk("st_c2_stall", stall, 1);
        mc_lat = 4'd1;
        tick();
        chk("st_c3_wb", mc_wb, 1);
        chk("st_c3_wb_rd", mc_wb_rd, 10);
        chk("st_c3_stall", stall, 0);
        chk("st_c3_cnt", stall_cnt, 6);
        tick();
        mc_start = 1'b0;
        chk("st_c4_busy", mc_busy, 1);
        chk("st_c4_wb", mc_wb, 0);
        tick();
        chk("st_c5_wb", mc_wb, 1);
        chk("st_c5_wb_rd", mc_wb_rd, 11);
        tick();
        chk("st_c6_busy", mc_busy, 0);
        chk("st_c6_wb", mc_wb, 0);

        // mc_lat = 0 behaves as 1; unused operand never stalls
        mc_start = 1'b1; mc_rd = 5'd12; mc_lat = 4'd0;
        tick();
        mc_start = 1'b0; rs1 = 5'd12; rs1_used = 1'b0; #1;
        chk("l0_busy", mc_busy, 1);
        chk("l0_unused_stall", stall, 0);
        rs1_used = 1'b1; #1;
        chk("l0_used_stall", stall, 1);
        rs1_used = 1'b0; #1;
        tick();
        chk("l0_wb", mc_wb, 1);
        chk("l0_wb_rd", mc_wb_rd, 12);
        rs1_used = 1'b1; #1;
        chk("l0_fwd_mc", fwd_a, 3);
        rs1_used = 1'b0; rs1 = '0;
        tick();
        chk("l0_idle", mc_wb, 0);
        chk("l0_cnt", stall_cnt, 6);

        // Reset mid-BUSY
        mc_start = 1'b1; mc_rd = 5'd13; mc_lat = 4'd4;
        tick();
        mc_start = 1'b0;
        chk("rb_busy", mc_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_busy0", mc_busy, 0);
        chk("rb_wb0", mc_wb, 0);
        chk("rb_wb_rd0", mc_wb_rd, 0);
        chk("rb_cnt0", stall_cnt, 0);
        #4 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rb_nowb_%0d", c), {mc_wb, mc_busy}, 0);
        end

        // Saturation of stall_cnt
        src_regwrite = 2'b01; src_rd = {5'd0, 5'd7}; src_ready = 2'b00;
        rs2 = 5'd7; rs2_used = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", stall, 1);
        chk("sat_cnt", stall_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
